// File: rtl/span_pkg.sv
// ---------------------------------------------------------------------------
// span_pkg
// Shared definitions for the span_cme register map and for the sequencer
// that feeds it.
//   OFF_*         span_cme register offsets (word k of a portfolio lands at
//                 offset k; OFF_CLEAR is unmapped and re-arms start flags)
//   seq_state_t   sequencer FSM states
// ---------------------------------------------------------------------------
package span_pkg;

    localparam logic [5:0] OFF_PSR           = 6'd0;
    localparam logic [5:0] OFF_POS_LAST      = 6'd8;
    localparam logic [5:0] OFF_OUTRIGHT_LAST = 6'd28;
    localparam logic [5:0] OFF_INTER_RATE    = 6'd33;
    localparam logic [5:0] OFF_CLEAR         = 6'd34;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        SETTLE,
        READ,
        CAPTURE,
        OUT
    } seq_state_t;

endpackage

// File: rtl/span_cme_sequencer.sv
// ---------------------------------------------------------------------------
// span_cme_sequencer
// Replays one portfolio (a stream of NUM_WORDS 16-bit words) as register
// writes on the span_cme bus, waits for the engines to settle, reads back the
// initial margin and offers it on a valid/ready port. Portfolios may follow
// each other back to back.
//
// Ports
//   clk, reset                      clock; synchronous active-low reset
//   in_data/in_valid/in_last        portfolio word stream
//   in_ready                        word accepted this cycle (LOAD, DRAIN)
//   cme_chipselect/write/read       span_cme bus strobes (registered)
//   cme_offset/cme_writeData        span_cme address/data (registered)
//   cme_readData                    span_cme read data (registered there)
//   margin_out/margin_valid         completed margin, held until accepted
//   margin_ready                    consumer accepts margin_out
//   busy                            high whenever the FSM is not IDLE
//   frame_err                       one-cycle pulse on a short or long frame
// ---------------------------------------------------------------------------
module span_cme_sequencer
    import span_pkg::*;
#(
    parameter int NUM_WORDS     = 34,
    parameter int CLEAR_OFFSET  = 34,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        cme_chipselect,
    output logic        cme_write,
    output logic        cme_read,
    output logic [5:0]  cme_offset,
    output logic [15:0] cme_writeData,
    input  logic [15:0] cme_readData,
    output logic [15:0] margin_out,
    output logic        margin_valid,
    input  logic        margin_ready,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [5:0] LAST_CNT    = 6'(NUM_WORDS - 1);
    localparam logic [5:0] CLR_OFF     = 6'(CLEAR_OFFSET);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    seq_state_t  state_r, state_s;
    logic [5:0]  cnt_r, cnt_s;
    logic [7:0]  settle_r, settle_s;
    logic        cs_r, cs_s;
    logic        wr_r, wr_s;
    logic        rd_r, rd_s;
    logic [5:0]  off_r, off_s;
    logic [15:0] wdata_r, wdata_s;
    logic [15:0] margin_r, margin_s;
    logic        mvalid_r, mvalid_s;
    logic        ferr_r, ferr_s;

    // Words are only taken while loading or draining, so a new portfolio
    // waits in IDLE/CLEAR and behind an undelivered result.
    assign in_ready       = (state_r == LOAD) || (state_r == DRAIN);
    assign busy           = (state_r != IDLE);
    assign cme_chipselect = cs_r;
    assign cme_write      = wr_r;
    assign cme_read       = rd_r;
    assign cme_offset     = off_r;
    assign cme_writeData  = wdata_r;
    assign margin_out     = margin_r;
    assign margin_valid   = mvalid_r;
    assign frame_err      = ferr_r;

    // Next-state and next-output logic; bus strobes default to idle so the
    // registered bus carries at most one strobe per cycle.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        settle_s = settle_r;
        cs_s     = 1'b0;
        wr_s     = 1'b0;
        rd_s     = 1'b0;
        off_s    = 6'd0;
        wdata_s  = 16'd0;
        margin_s = margin_r;
        mvalid_s = mvalid_r;
        ferr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // The pending word is left on the input; only the clear
                // write is launched so it shows up while in CLEAR.
                if (in_valid) begin
                    state_s = CLEAR;
                    cs_s    = 1'b1;
                    wr_s    = 1'b1;
                    off_s   = CLR_OFF;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                state_s = LOAD;
                cnt_s   = OFF_PSR;
            end
            LOAD: begin
                if (in_valid) begin
                    if (in_last && (cnt_r != LAST_CNT)) begin
                        // Short frame: the final word is dropped.
                        ferr_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        cs_s    = 1'b1;
                        wr_s    = 1'b1;
                        off_s   = cnt_r;
                        wdata_s = in_data;
                        cnt_s   = cnt_r + 6'd1;
                        if (cnt_r == LAST_CNT) begin
                            if (in_last) begin
                                settle_s = SETTLE_LOAD;
                                state_s  = SETTLE;
                            end else begin
                                // Long frame: keep the full map, skip the rest.
                                ferr_s  = 1'b1;
                                state_s = DRAIN;
                            end
                        end else begin
                            state_s = LOAD;
                        end
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            DRAIN: begin
                if (in_valid && in_last) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            SETTLE: begin
                // The read is launched from here so it lands in READ; the
                // entry cycle overlaps the last write, giving SETTLE_CYCLES
                // fully idle cycles before the read.
                if (settle_r == 8'd0) begin
                    state_s = READ;
                    cs_s    = 1'b1;
                    rd_s    = 1'b1;
                end else begin
                    settle_s = settle_r - 8'd1;
                end
            end
            READ: begin
                state_s = CAPTURE;
            end
            CAPTURE: begin
                margin_s = cme_readData;
                mvalid_s = 1'b1;
                state_s  = OUT;
            end
            OUT: begin
                if (margin_ready) begin
                    mvalid_s = 1'b0;
                    state_s  = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= 6'd0;
            settle_r <= 8'd0;
            cs_r     <= 1'b0;
            wr_r     <= 1'b0;
            rd_r     <= 1'b0;
            off_r    <= 6'd0;
            wdata_r  <= 16'd0;
            margin_r <= 16'd0;
            mvalid_r <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            settle_r <= settle_s;
            cs_r     <= cs_s;
            wr_r     <= wr_s;
            rd_r     <= rd_s;
            off_r    <= off_s;
            wdata_r  <= wdata_s;
            margin_r <= margin_s;
            mvalid_r <= mvalid_s;
            ferr_r   <= ferr_s;
        end
    end

endmodule
